// File: rtl/wt_cache_controller.sv
// ----------------------------------------------------------------------------
// wt_cache_controller
//
// Direct-mapped, write-through, no-write-allocate cache controller between
// the processor port and a 1K-word main memory. Each line holds one 128-bit
// block (4 words). Read hits complete with no wait. A read miss fetches the
// whole block. Every write goes to memory while the processor is stalled, and
// the line is updated only when the write hits.
//
// Parameters
//   LINES       number of cache lines (power of two, default 32)
//
// Ports
//   clk         single clock; all controller state updates on posedge
//   rst_n       synchronous active-low reset
//   cpu_read    read request, held until a cycle with stall=0
//   cpu_write   write request, held the same way (wins over cpu_read)
//   cpu_addr    word address {tag, index, offset[1:0]}
//   cpu_wdata   write data
//   cpu_rdata   read data, valid when cpu_read=1 and stall=0
//   stall       processor must hold its request while high
//   read_main   registered block read request to memory
//   write_main  registered word write request to memory
//   mem_addr    registered request address
//   mem_wdata   registered write data
//   mem_ready   one-cycle completion pulse from memory
//   mem_block   block at {mem_addr[9:2], 2'b00}, word k at [32k+31:32k]
//
// Optional feature (macro CACHE_STATS_EN):
//   hit_count   saturating count of read hits
//   miss_count  saturating count of read misses (counted in DONE)
// ----------------------------------------------------------------------------
module wt_cache_controller #(
    parameter int LINES = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [9:0]   cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         stall,
    output logic         read_main,
    output logic         write_main,
    output logic [9:0]   mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic         mem_ready,
    input  logic [127:0] mem_block
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 8 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_MEM,
        WR_MEM,
        DONE
    } state_t;

    state_t state, state_next;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     data_q [LINES];
    logic             hit_q;          // write hit flag, latched when the write is issued

    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] mem_idx;
    logic [TAG_W-1:0] mem_tag;
    logic             hit;

    assign cpu_idx = cpu_addr[IDX_W+1:2];
    assign cpu_tag = cpu_addr[9:IDX_W+2];
    assign mem_idx = mem_addr[IDX_W+1:2];
    assign mem_tag = mem_addr[9:IDX_W+2];

    assign hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    // The processor holds its address through DONE, so the same word select
    // serves both the IDLE hit path and the DONE completion cycle.
    assign cpu_rdata = data_q[cpu_idx][{cpu_addr[1:0], 5'b00000} +: 32];

    // ------------------------------------------------------------------------
    // Next-state and stall
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement leaves it unassigned (no latches).
        state_next = state;
        stall      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_write) begin
                    stall      = 1'b1;
                    state_next = WR_MEM;
                end else if (cpu_read && !hit) begin
                    stall      = 1'b1;
                    state_next = RD_MEM;
                end
            end
            RD_MEM, WR_MEM: begin
                stall = 1'b1;
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, memory request registers and valid bits
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state      <= IDLE;
            valid_q    <= '0;
            read_main  <= 1'b0;
            write_main <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_q      <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (cpu_write) begin
                        write_main <= 1'b1;
                        mem_addr   <= cpu_addr;
                        mem_wdata  <= cpu_wdata;
                        hit_q      <= hit;
                    end else if (cpu_read && !hit) begin
                        read_main <= 1'b1;
                        mem_addr  <= cpu_addr;
                    end
                end
                RD_MEM: begin
                    if (mem_ready) begin
                        read_main        <= 1'b0;
                        valid_q[mem_idx] <= 1'b1;
                    end
                end
                WR_MEM: begin
                    if (mem_ready) begin
                        write_main <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Tag and data arrays
    // ------------------------------------------------------------------------
    // NOTE: the arrays carry no reset; the valid bits alone decide whether a
    // line's contents mean anything, which keeps them mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n && mem_ready) begin
            if (state == RD_MEM) begin
                tag_q[mem_idx]  <= mem_tag;
                data_q[mem_idx] <= mem_block;
            end else if (state == WR_MEM && hit_q) begin
                data_q[mem_idx][{mem_addr[1:0], 5'b00000} +: 32] <= mem_wdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // ------------------------------------------------------------------------
    // Read statistics: hits count in IDLE, misses in the DONE after a fill.
    // ------------------------------------------------------------------------
    logic rd_fill_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            rd_fill_q  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                rd_fill_q <= cpu_read && !cpu_write && !hit;
                if (cpu_read && !cpu_write && hit && hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end
            if (state == DONE && rd_fill_q && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/wt_cache_controller.md
# wt_cache_controller

Direct-mapped, write-through, no-write-allocate cache controller sitting between the processor port and the team's 1K-word main memory. It is the initiator on the memory request/ready interface. It serves read hits without a memory access, fetches 128-bit blocks on read misses, and forwards every write to memory while stalling the processor.

## Interface
- LINES, default 32: cache lines, 4 words each. Index width = log2(LINES), tag width = 8 − log2(LINES).
- clk  in  1  single clock; all controller state updates on posedge. The memory samples on negedge.
- rst_n  in  1  synchronous, active-low reset.
- cpu_read  in  1  read request, held until a cycle with stall=0.
- cpu_write  in  1  write request, held the same way. Takes priority if asserted together with cpu_read.
- cpu_addr  in  10  word address: tag [9:2+idx], index [idx+1:2], offset [1:0].
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data. Valid in any cycle where cpu_read=1 and stall=0.
- stall  out  1  processor must hold its request while this is high.
- read_main  out  1  block read request to memory, registered.
- write_main  out  1  word write request to memory, registered.
- mem_addr  out  10  registered copy of the request address.
- mem_wdata  out  32  registered copy of the write data.
- mem_ready  in  1  one-cycle completion pulse from memory.
- mem_block  in  128  block at {mem_addr[9:2], 2'b00}; word k is at bits [32k+31:32k].

## Operation
- Storage: valid[LINES], tag[LINES], data[LINES] × 128 bits. Hit = valid[idx] and tag matches.
- States:
  - IDLE: default state.
  - RD_MEM: block read in progress.
  - WR_MEM: word write in progress.
  - DONE: single-cycle completion state.
- IDLE:
  - Read hit: cpu_rdata is taken from the line word selected by cpu_addr[1:0], combinationally. stall=0. Stay in IDLE.
  - Read miss: stall=1. Latch the address and go to RD_MEM with read_main=1.
  - Write (hit or miss): stall=1. Latch address and data, plus the hit flag. Go to WR_MEM with write_main=1.
- RD_MEM: hold read_main, mem_addr and stall=1 until mem_ready=1 is sampled. On that edge:
  - write mem_block into the line, set valid and the tag;
  - drop read_main;
  - go to DONE.
- WR_MEM: hold write_main, mem_addr, mem_wdata and stall=1 until mem_ready=1. On that edge:
  - if the latched hit flag is set, update only the addressed 32-bit word of the line;
  - on a miss, leave the cache unchanged;
  - drop write_main and go to DONE.
- DONE: stall=0, and cpu_rdata is driven from the line. Return to IDLE unconditionally. A request is not re-evaluated in this cycle.
- read_main and write_main are never high together.
- mem_addr and mem_wdata stay stable for the whole time a request is high.
- No request is outstanding in IDLE or DONE.

## Timing
- Reset values:
  - state IDLE; all valid bits 0;
  - read_main=0, write_main=0, mem_addr=0, mem_wdata=0;
  - stall follows its combinational rule, so stall=0 while idle with no request.
- Read hit: 0 stall cycles.
- Miss or write with memory ready after N cycles of request: stall is high for N+1 cycles, followed by one DONE cycle with stall=0.
- The team main memory gives N=5: ready is seen at the 5th posedge after read_main or write_main rises.
- mem_ready sampled in IDLE or DONE is ignored.
- Reset mid-transaction clears the state and drops requests at that edge. Memory-side counters are not reset by this block, so system reset must reset both blocks.
- Back-to-back requests: the next request is evaluated in the IDLE cycle after DONE.

## Configuration
- CACHE_STATS_EN defined:
  - adds outputs hit_count[15:0] and miss_count[15:0];
  - each increments once per completed read (hit in IDLE, miss in DONE) and saturates at 16'hFFFF;
  - writes are not counted;
  - both clear on rst_n=0.
- CACHE_STATS_EN undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Cold read: after reset, read addr 10'h045 with memory word 10'h045 = 32'hDEAD_BEEF.
  - Expect read_main high for 5 cycles, then DONE with cpu_rdata = 32'hDEAD_BEEF.
  - Total stall: 6 cycles.
- Read hit: then read 10'h046 (same block, memory word = 32'h1234_5678). Expect stall=0, cpu_rdata = 32'h1234_5678, and read_main stays 0.
- Write hit: write 32'hCAFE_0001 to 10'h045.
  - Expect write_main=1 with mem_addr = 10'h045 and mem_wdata = 32'hCAFE_0001 until ready; memory updated.
  - A following read of 10'h045 hits and returns 32'hCAFE_0001.
- Write miss: write 32'h0000_00AA to 10'h3C5 (same index, different tag).
  - Expect memory updated and the line unchanged.
  - Read 10'h045 still hits; read 10'h3C5 misses and fetches 32'h0000_00AA.
- Conflict and simultaneous events:
  - A read of 10'h3C5 after a read of 10'h045 evicts the line, so a re-read of 10'h045 misses.
  - With cpu_read and cpu_write both high, only write_main asserts.
- Reset mid-RD_MEM: assert rst_n=0 for one cycle during RD_MEM. Expect read_main=0 next cycle, all lines invalid, and the next read misses.
